// File: rtl/md_unit_if.sv
// Purpose : bundles the multiply/divide unit's request, MT-write and result signals.
// Ports   : master drives Start/MDOp/A/B/WHi/WLo and observes Busy/HI/LO;
//           slave (the md_unit) is the mirror image.
interface md_unit_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        WHi;
  logic        WLo;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDOp, A, B, WHi, WLo,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, MDOp, A, B, WHi, WLo,
    output Busy, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Purpose : MIPS-style HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO),
//           with optional MADD/MADDU accumulate enabled by macro MD_UNIT_MADD_EN.
// Latency : multiply/accumulate 5 cycles, divide 10 cycles; Busy is high for exactly
//           that many cycles and HI/LO update on the edge where Busy falls.
// Backpressure : none internally; while Busy, Start/WHi/WLo are ignored (the
//           pipeline's hazard unit stalls on Start|Busy).
// Ports   : clk, reset (async active-low), md (md_unit_if.slave: Start, MDOp, A, B,
//           WHi, WLo in; Busy, HI, LO out).
module md_unit (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  // Counter is loaded with latency-1 and the result lands when it reads zero,
  // so Busy covers exactly 5 or 10 cycles.
  localparam logic [3:0] MUL_LOAD = 4'd4;
  localparam logic [3:0] DIV_LOAD = 4'd9;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;
  logic        busy;

  logic legal, start_div, accept;

`ifdef MD_UNIT_MADD_EN
  assign legal = (md.MDOp <= 3'd5);
`else
  assign legal = (md.MDOp <= 3'd3);
`endif
  assign start_div = (md.MDOp == 3'd2) || (md.MDOp == 3'd3);
  assign accept    = (state == IDLE) && md.Start && legal;

  // Datapath works only on the latched operands, so A/B changes after Start are harmless.
  logic        sgn, a_neg, b_neg;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    sgn   = (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
    // Low 64 bits of the sign-extended product equal the signed product mod 2^64.
    ext_a = {{32{sgn & op_a[31]}}, op_a};
    ext_b = {{32{sgn & op_b[31]}}, op_b};
    prod  = ext_a * ext_b;
    // Divide on magnitudes, then restore signs: quotient truncates toward zero and
    // the remainder follows the dividend. 0x80000000/-1 falls out as 0x80000000 rem 0.
    a_neg = sgn & op_a[31];
    b_neg = sgn & op_b[31];
    a_mag = a_neg ? (~op_a + 32'd1) : op_a;
    b_mag = b_neg ? (~op_b + 32'd1) : op_b;
    q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // State register (plus the registers the FSM controls).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op    <= 3'd0;
      op_a  <= 32'd0;
      op_b  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      if (accept) begin
        op   <= md.MDOp;
        op_a <= md.A;
        op_b <= md.B;
        cnt  <= start_div ? DIV_LOAD : MUL_LOAD;
      end else if (state != IDLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Next-state logic. The completion cycle goes straight to IDLE, so a Start seen
  // on that edge is not accepted; the earliest back-to-back Start is one edge later.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_div ? DIV : MUL;
      MUL,
      DIV:     if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: HI/LO change only on MT writes in IDLE or on the completion cycle.
  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    case (state)
      IDLE: begin
        // An accepted Start takes priority and drops any simultaneous MT write.
        if (!accept) begin
          if (md.WHi) hi_nxt = md.A;
          if (md.WLo) lo_nxt = md.A;
        end
      end
      MUL: begin
        if (cnt == 4'd0) begin
`ifdef MD_UNIT_MADD_EN
          if (op[2]) {hi_nxt, lo_nxt} = {hi, lo} + prod;
          else
`endif
          {hi_nxt, lo_nxt} = prod;
        end
      end
      DIV: begin
        // Divide by zero runs the full latency but leaves HI/LO untouched.
        if (cnt == 4'd0 && op_b != 32'd0) begin
          hi_nxt = rem;
          lo_nxt = quot;
        end
      end
      default: ;
    endcase
  end

  assign md.Busy = busy;
  assign md.HI   = hi;
  assign md.LO   = lo;
endmodule
